// File: rtl/ex_stage_pkg.sv
// rtl/ex_stage_pkg.sv - shared encodings, bus widths and muldiv state constants for the execute stage
package ex_stage_pkg;

    localparam int RTLOP_BUS   = 5;
    localparam int RTLTYPE_BUS = 3;
    localparam int DATA_BUS    = 32;
    localparam int REG_BUS     = 5;

    typedef enum logic [RTLOP_BUS-1:0] {
        OP_ADD    = 5'd0,
        OP_SUB    = 5'd1,
        OP_SLL    = 5'd2,
        OP_SLT    = 5'd3,
        OP_SLTU   = 5'd4,
        OP_XOR    = 5'd5,
        OP_SRL    = 5'd6,
        OP_SRA    = 5'd7,
        OP_OR     = 5'd8,
        OP_AND    = 5'd9,
        OP_MUL    = 5'd10,
        OP_MULH   = 5'd11,
        OP_MULHSU = 5'd12,
        OP_MULHU  = 5'd13,
        OP_DIV    = 5'd14,
        OP_DIVU   = 5'd15,
        OP_REM    = 5'd16,
        OP_REMU   = 5'd17
    } rtlop_e;

    typedef enum logic [RTLTYPE_BUS-1:0] {
        RT_NOP    = 3'd0,
        RT_ALU    = 3'd1,
        RT_MULDIV = 3'd2,
        RT_LOAD   = 3'd3,
        RT_STORE  = 3'd4,
        RT_BRANCH = 3'd5
    } rtltype_e;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } md_state_e;

    // muldiv codes are contiguous so class decode is a range check
    function automatic logic is_muldiv(input logic [RTLOP_BUS-1:0] op);
        return (op >= OP_MUL) && (op <= OP_REMU);
    endfunction

    function automatic logic is_div(input logic [RTLOP_BUS-1:0] op);
        return (op >= OP_DIV) && (op <= OP_REMU);
    endfunction

    // first operand is treated as two's complement
    function automatic logic signed_a(input logic [RTLOP_BUS-1:0] op);
        return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    // second operand is treated as two's complement
    function automatic logic signed_b(input logic [RTLOP_BUS-1:0] op);
        return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/ex_muldiv.sv
// rtl/ex_muldiv.sv - iterative shift-add multiplier / restoring divider with IDLE-BUSY-DONE sequencing
module ex_muldiv import ex_stage_pkg::*; #(
    parameter int XLEN      = 32,
    parameter int MD_CYCLES = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 start,
    input  logic [RTLOP_BUS-1:0] op,
    input  logic [XLEN-1:0]      src1,
    input  logic [XLEN-1:0]      src2,
    output logic                 stall,
    output logic                 done,
    output logic [XLEN-1:0]      result
);

    localparam int CNT_W = $clog2(MD_CYCLES + 1);

    md_state_e              state;
    logic [CNT_W-1:0]       cnt;
    logic [RTLOP_BUS-1:0]   op_q;
    // acc: product high half or partial remainder; lo: product low half or quotient
    logic [XLEN-1:0]        acc;
    logic [XLEN-1:0]        lo;
    logic [XLEN-1:0]        dvs;
    logic                   neg_q;
    logic                   neg_r;

    logic                   sa;
    logic                   sb;
    logic [XLEN-1:0]        mag1;
    logic [XLEN-1:0]        mag2;
    logic                   div_zero;
    logic                   div_ovf;

    logic [XLEN:0]          mul_sum;
    logic [XLEN:0]          div_sh;
    logic [XLEN:0]          div_diff;
    logic [XLEN-1:0]        acc_n;
    logic [XLEN-1:0]        lo_n;

    logic [2*XLEN-1:0]      prod;
    logic [2*XLEN-1:0]      prod_s;
    logic [XLEN-1:0]        quo_s;
    logic [XLEN-1:0]        rem_s;

    // operand magnitudes and the two cases that bypass iteration
    always_comb begin
        sa       = signed_a(op) & src1[XLEN-1];
        sb       = signed_b(op) & src2[XLEN-1];
        mag1     = sa ? -src1 : src1;
        mag2     = sb ? -src2 : src2;
        div_zero = is_div(op) && (src2 == '0);
        div_ovf  = ((op == OP_DIV) || (op == OP_REM))
                   && (src1 == {1'b1, {(XLEN-1){1'b0}}})
                   && (src2 == '1);
    end

    // one shift-add or restoring-subtract step, selected by the latched op
    always_comb begin
        mul_sum  = {1'b0, acc} + (lo[0] ? {1'b0, dvs} : {(XLEN+1){1'b0}});
        div_sh   = {acc, lo[XLEN-1]};
        div_diff = div_sh - {1'b0, dvs};
        acc_n    = mul_sum[XLEN:1];
        lo_n     = {mul_sum[0], lo[XLEN-1:1]};
        if (is_div(op_q)) begin
            if (!div_diff[XLEN]) begin
                acc_n = div_diff[XLEN-1:0];
                lo_n  = {lo[XLEN-2:0], 1'b1};
            end else begin
                acc_n = div_sh[XLEN-1:0];
                lo_n  = {lo[XLEN-2:0], 1'b0};
            end
        end
    end

    // sign correction of the magnitude result, presented while in DONE
    always_comb begin
        prod   = {acc, lo};
        prod_s = neg_q ? -prod : prod;
        quo_s  = neg_q ? -lo : lo;
        rem_s  = neg_r ? -acc : acc;
        case (op_q)
            OP_MUL:                       result = prod_s[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: result = prod_s[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              result = quo_s;
            OP_REM, OP_REMU:              result = rem_s;
            default:                      result = '0;
        endcase
    end

    // sequencer: latch on arrival, iterate MD_CYCLES times, present for one cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= MD_IDLE;
            cnt   <= '0;
            op_q  <= '0;
            acc   <= '0;
            lo    <= '0;
            dvs   <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (flush) begin
            state <= MD_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                MD_IDLE: begin
                    if (start) begin
                        op_q <= op;
                        cnt  <= '0;
                        if (div_zero) begin
                            lo    <= '1;
                            acc   <= src1;
                            dvs   <= src2;
                            neg_q <= 1'b0;
                            neg_r <= 1'b0;
                            state <= MD_DONE;
                        end else if (div_ovf) begin
                            lo    <= src1;
                            acc   <= '0;
                            dvs   <= src2;
                            neg_q <= 1'b0;
                            neg_r <= 1'b0;
                            state <= MD_DONE;
                        end else begin
                            acc   <= '0;
                            neg_q <= sa ^ sb;
                            neg_r <= sa;
                            state <= MD_BUSY;
                            if (is_div(op)) begin
                                lo  <= mag1;
                                dvs <= mag2;
                            end else begin
                                lo  <= mag2;
                                dvs <= mag1;
                            end
                        end
                    end
                end
                MD_BUSY: begin
                    acc <= acc_n;
                    lo  <= lo_n;
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(MD_CYCLES - 1)) begin
                        state <= MD_DONE;
                    end
                end
                MD_DONE: begin
                    state <= MD_IDLE;
                end
                default: begin
                    state <= MD_IDLE;
                end
            endcase
        end
    end

    assign stall = !rst && !flush
                   && (((state == MD_IDLE) && start) || (state == MD_BUSY));
    assign done  = !rst && !flush && (state == MD_DONE);

endmodule

// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - execute stage: single-cycle ALU plus optional iterative muldiv (EX_MULDIV_EN)
module ex_stage import ex_stage_pkg::*; #(
    parameter int XLEN      = 32,
    parameter int MD_CYCLES = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   ex_valid,
    input  logic [RTLOP_BUS-1:0]   ex_rtlop_i,
    input  logic [RTLTYPE_BUS-1:0] ex_rtltype_i,
    input  logic [XLEN-1:0]        ex_pc_i,
    input  logic [XLEN-1:0]        ex_src1_i,
    input  logic [XLEN-1:0]        ex_src2_i,
    input  logic [REG_BUS-1:0]     ex_gprs_waddr_i,
    output logic                   ex_stall_req,
    output logic                   exmem_valid,
    output logic [XLEN-1:0]        exmem_result,
    output logic [XLEN-1:0]        exmem_pc,
    output logic [RTLTYPE_BUS-1:0] exmem_rtltype,
    output logic [REG_BUS-1:0]     exmem_gprs_waddr
);

    logic [4:0]      shamt;
    logic [XLEN-1:0] alu_res;
    logic            is_md;

    assign shamt = ex_src2_i[4:0];
    assign is_md = is_muldiv(ex_rtlop_i);

    assign exmem_pc         = ex_pc_i;
    assign exmem_rtltype    = ex_rtltype_i;
    assign exmem_gprs_waddr = ex_gprs_waddr_i;

    // single-cycle integer ALU
    always_comb begin
        alu_res = '0;
        case (ex_rtlop_i)
            OP_ADD:  alu_res = ex_src1_i + ex_src2_i;
            OP_SUB:  alu_res = ex_src1_i - ex_src2_i;
            OP_SLL:  alu_res = ex_src1_i << shamt;
            OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(ex_src1_i) < $signed(ex_src2_i)};
            OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, ex_src1_i < ex_src2_i};
            OP_XOR:  alu_res = ex_src1_i ^ ex_src2_i;
            OP_SRL:  alu_res = ex_src1_i >> shamt;
            OP_SRA:  alu_res = XLEN'($signed(ex_src1_i) >>> shamt);
            OP_OR:   alu_res = ex_src1_i | ex_src2_i;
            OP_AND:  alu_res = ex_src1_i & ex_src2_i;
            default: alu_res = '0;
        endcase
    end

`ifdef EX_MULDIV_EN
    logic            md_stall;
    logic            md_done;
    logic [XLEN-1:0] md_result;

    ex_muldiv #(
        .XLEN      (XLEN),
        .MD_CYCLES (MD_CYCLES)
    ) u_muldiv (
        .clk    (clk),
        .rst    (rst),
        .flush  (flush),
        .start  (ex_valid && is_md),
        .op     (ex_rtlop_i),
        .src1   (ex_src1_i),
        .src2   (ex_src2_i),
        .stall  (md_stall),
        .done   (md_done),
        .result (md_result)
    );
`else
    // the clock only feeds the iterative unit, which is absent in this build
    logic unused_clk;
    assign unused_clk = clk;
`endif

    // result select, valid and stall; reset and flush silence both handshakes
    always_comb begin
        exmem_valid  = 1'b0;
        exmem_result = alu_res;
        ex_stall_req = 1'b0;
`ifdef EX_MULDIV_EN
        ex_stall_req = md_stall;
        if (md_done) begin
            exmem_valid  = 1'b1;
            exmem_result = md_result;
        end else if (is_md) begin
            exmem_valid  = 1'b0;
            exmem_result = '0;
        end else
`else
        if (is_md) begin
            exmem_valid  = ex_valid;
            exmem_result = '0;
        end else
`endif
        begin
            exmem_valid = ex_valid;
        end
        if (rst || flush) begin
            exmem_valid  = 1'b0;
            ex_stall_req = 1'b0;
        end
    end

endmodule
